// File: rtl/radio_pll_sequencer_if.sv
// Request/response bundle between the timing engine and the PLL sequencer.
// Latency: none, plain wires.
// Backpressure: none; requests are levels and the responder reports status levels.
interface radio_pll_sequencer_if #(
  parameter int BIT_WIDTH = 2
);
  logic                 isolate;
  logic [BIT_WIDTH-1:0] radioEnable;
  logic [BIT_WIDTH-1:0] radioRxEn;
  logic [BIT_WIDTH-1:0] tArstFs;
  logic [BIT_WIDTH-1:0] pllSettled;
  logic [BIT_WIDTH-1:0] busy;

  // Timing engine side: drives requests, observes status.
  modport master (
    output isolate, radioEnable, radioRxEn,
    input  tArstFs, pllSettled, busy
  );

  // Sequencer side: observes requests, drives status.
  modport slave (
    input  isolate, radioEnable, radioRxEn,
    output tArstFs, pllSettled, busy
  );
endinterface

// File: rtl/radio_pll_sequencer.sv
// Per-lane PLL start-up sequencer: fast-settle reset pulse, then settle count, then locked.
// Latency: pllSettled rises FS_RST_CYCLES + SETTLE_x_CYCLES edges after the request is first sampled.
// Backpressure: none; dropping the request (or isolate) returns the lane to IDLE at the next edge.
module radio_pll_sequencer #(
  parameter int BIT_WIDTH        = 2,
  parameter int FS_RST_CYCLES    = 4,
  parameter int SETTLE_TX_CYCLES = 16,
  parameter int SETTLE_RX_CYCLES = 24,
  parameter int CNT_WIDTH        = 8
) (
  input  logic                 ck,
  input  logic                 arst,
  radio_pll_sequencer_if.slave bus
);

  localparam int CNT_MAX = (1 << CNT_WIDTH) - 1;

  // Every cycle count must be loadable as (count - 1) into the lane counter.
  if (FS_RST_CYCLES < 1 || FS_RST_CYCLES > CNT_MAX) begin : g_bad_fs
    $error("FS_RST_CYCLES out of range for CNT_WIDTH");
  end
  if (SETTLE_TX_CYCLES < 1 || SETTLE_TX_CYCLES > CNT_MAX) begin : g_bad_tx
    $error("SETTLE_TX_CYCLES out of range for CNT_WIDTH");
  end
  if (SETTLE_RX_CYCLES < 1 || SETTLE_RX_CYCLES > CNT_MAX) begin : g_bad_rx
    $error("SETTLE_RX_CYCLES out of range for CNT_WIDTH");
  end

  localparam logic [CNT_WIDTH-1:0] FS_LOAD = CNT_WIDTH'(FS_RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TX_LOAD = CNT_WIDTH'(SETTLE_TX_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] RX_LOAD = CNT_WIDTH'(SETTLE_RX_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FSRST  = 2'd1,
    SETTLE = 2'd2,
    LOCKED = 2'd3
  } state_t;

  logic [BIT_WIDTH-1:0] tarst_vec;
  logic [BIT_WIDTH-1:0] settled_vec;
  logic [BIT_WIDTH-1:0] busy_vec;

  for (genvar i = 0; i < BIT_WIDTH; i++) begin : g_lane
    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 mode_q, mode_d;
    logic                 req, mode;
    logic                 tarst_q, settled_q, busy_q;

    // The source domain may be powered down: isolate clamps both request bits low.
    assign req  = bus.radioEnable[i] & ~bus.isolate;
    assign mode = bus.radioRxEn[i]   & ~bus.isolate;

    // Next-state and counter logic; a dropped request always wins.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      case (state_q)
        IDLE: begin
          if (req) begin
            state_d = FSRST;
            cnt_d   = FS_LOAD;
          end
        end
        FSRST: begin
          if (!req) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            state_d = SETTLE;
            mode_d  = mode;
            cnt_d   = mode ? RX_LOAD : TX_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        SETTLE: begin
          if (!req) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            state_d = LOCKED;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        LOCKED: begin
          if (!req) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (mode != mode_q) begin
            // Retune to the other band without another fast-settle pulse.
            state_d = SETTLE;
            mode_d  = mode;
            cnt_d   = mode ? RX_LOAD : TX_LOAD;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // State register plus output flops decoded from the next state, so outputs are glitch-free.
    always_ff @(posedge ck or negedge arst) begin
      if (!arst) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        mode_q    <= 1'b0;
        tarst_q   <= 1'b0;
        settled_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        mode_q    <= mode_d;
        tarst_q   <= (state_d == FSRST);
        settled_q <= (state_d == LOCKED);
        busy_q    <= (state_d == FSRST) || (state_d == SETTLE);
      end
    end

    assign tarst_vec[i]   = tarst_q;
    assign settled_vec[i] = settled_q;
    assign busy_vec[i]    = busy_q;
  end

  assign bus.tArstFs    = tarst_vec;
  assign bus.pllSettled = settled_vec;
  assign bus.busy       = busy_vec;

endmodule
